sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Parametrised single-clock FIFO; next generation of the team's FIFO blocks. Keeps the winc/rinc, wdata/rdata and wfull/rempty conventions.
- Adds almost-full and almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a first-word-fall-through (FWFT) mode.
- Used where producer and consumer share one clock. Also used as the staging buffer behind clock-domain crossings.

Parameters:
- DSIZE, 8, data width in bits.
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
- AFULL_TH, 12, walmost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, ralmost_empty asserts when count <= AEMPTY_TH.
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- Legal range: 0 <= AEMPTY_TH < AFULL_TH <= DEPTH. Anything else is an elaboration error.

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- winc  input  1  write request.
- wdata  input  DSIZE  write data, sampled on an accepted write.
- wfull  output  1  count == DEPTH.
- walmost_full  output  1  count >= AFULL_TH.
- rinc  input  1  read request.
- rdata  output  DSIZE  read data.
- rempty  output  1  count == 0.
- ralmost_empty  output  1  count <= AEMPTY_TH.
- count  output  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a write was attempted while full.
- underflow  output  1  sticky; a read was attempted while empty.
- clr_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - wptr=0, rptr=0, count=0, rdata=0, overflow=0, underflow=0.
  - Outputs therefore reset to rempty=1, ralmost_empty=1, wfull=0, walmost_full=0 (AFULL_TH >= 1).
  - Memory array is not reset.
  - Deassertion is used synchronously, first active edge after release.
- Pointers:
  - wptr and rptr are ASIZE+1 bits; the lower ASIZE bits address the array.
  - Pointers wrap modulo 2**(ASIZE+1).
- Write accept: winc && !wfull at posedge. Effects: mem[wptr] <= wdata, wptr+1.
- Read accept: rinc && !rempty at posedge. Effect: rptr+1.
- Count update:
  - +1 on write-only, -1 on read-only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH, never below 0.
- Simultaneous winc and rinc:
  - Both accepted when 0 < count < DEPTH.
  - When full: read accepted, write rejected. Count becomes DEPTH-1; overflow sets.
  - When empty: write accepted, read rejected. Count becomes 1; underflow sets.
  - There is no same-cycle bypass.
- Flags:
  - wfull, rempty, walmost_full and ralmost_empty are decoded only from the count register.
  - No combinational path from winc/rinc to any flag.
  - Flags change on the edge after the causing access.
- Error flags:
  - overflow sets on any edge with winc && wfull.
  - underflow sets on any edge with rinc && rempty.
  - Both hold until clr_err=1 at an edge.
  - If set and clear occur in the same cycle, set wins.
- FWFT=0 (standard read):
  - On an accepted read, rdata <= mem[rptr] at that edge; data is valid in the following cycle.
  - rdata holds its last value otherwise, including on a rejected read.
- FWFT=1 (first-word-fall-through):
  - rdata = mem[rptr] whenever rempty=0, with no rinc needed.
  - rdata = 0 whenever rempty=1.
  - A word written to an empty FIFO appears on rdata in the cycle after the write edge.
  - rinc pops the word; rdata shows the next word, or 0, from the following cycle.
- Memory read/write address collision is impossible by construction: a read never targets an entry being written in the same cycle.

Test Plan:
Configuration for all scenarios: DSIZE=8, ASIZE=4 (DEPTH=16), AFULL_TH=12, AEMPTY_TH=2.
1. Reset → rdata=0x00, count=0, rempty=1, ralmost_empty=1, wfull=0, walmost_full=0, overflow=0, underflow=0.
2. Fill and overflow:
   - Write 0x01..0x10, one per cycle → ralmost_empty drops after the 3rd write, walmost_full rises after the 12th, wfull rises after the 16th.
   - 17th write of 0xFF → rejected; count stays 16, overflow=1.
   - Then winc=rinc=1 at full → count=15, overflow stays 1.
   - Then clr_err → overflow=0.
3. Standard drain (FWFT=0), starting from 16 entries → rdata shows 0x01..0x10, each one cycle after its rinc; rempty=1 after the 16th read.
   - Extra read → underflow=1, rdata holds 0x10.
4. Steady-state at count=8: winc=rinc=1 for 40 cycles with incrementing data → count stays 8, both pointers wrap, output order is exactly the input order, no error flags.
5. FWFT mode (FWFT=1):
   - Write 0xA5 to empty → next cycle rempty=0 and rdata=0xA5 with no rinc.
   - Write 0x5A, then rinc → next cycle rdata=0x5A.
   - rinc again → next cycle rempty=1, rdata=0x00.
6. Reset mid-operation at count=9 with overflow=1 → count, flags and rdata return to reset values immediately.
   - After release, writing 0x3C then reading returns 0x3C, not stale data.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional
// first-word-fall-through read port.
//
// Parameters
//   DSIZE      data width
//   ASIZE      address width, DEPTH = 2**ASIZE
//   AFULL_TH   walmost_full  when count >= AFULL_TH
//   AEMPTY_TH  ralmost_empty when count <= AEMPTY_TH
//   FWFT       0: registered read on rinc, 1: head word always on rdata
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   winc, wdata         write request and data
//   wfull, walmost_full write-side status
//   rinc, rdata         read request and data
//   rempty, ralmost_empty read-side status
//   count               occupancy 0..DEPTH
//   overflow, underflow sticky error flags
//   clr_err             synchronous clear of the error flags
//
// Handshake: winc and rinc are requests. A write transfers on a posedge
// where winc=1 and wfull=0; a read transfers on a posedge where rinc=1 and
// rempty=0. A request made against a full/empty FIFO has no effect other
// than setting overflow/underflow. All status flags are decoded from the
// count register only, so they change on the edge after the access.
// ---------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int DEPTH = 1 << ASIZE;

    localparam logic [ASIZE:0] DEPTH_C   = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_C   = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_C  = (ASIZE+1)'(AEMPTY_TH);

    generate
        if (!((AEMPTY_TH >= 0) && (AEMPTY_TH < AFULL_TH) && (AFULL_TH <= DEPTH))) begin : g_bad_params
            $error("sync_fifo_ctrl: need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
        end
    endgenerate

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come from the registered count only.
    assign wfull         = (count == DEPTH_C);
    assign rempty        = (count == '0);
    assign walmost_full  = (count >= AFULL_C);
    assign ralmost_empty = (count <= AEMPTY_C);

    assign wr_acc = winc && !wfull;
    assign rd_acc = rinc && !rempty;

    // Storage is not reset; entries are only ever read after being written.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rinc && rempty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally from the array; a word
            // written to an empty FIFO shows up once count has incremented.
            assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];
        end else begin : g_std
            logic [DSIZE-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= mem[rptr[ASIZE-1:0]];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

    // Pointer distance must always equal the occupancy count.
    a_ptr_count : assert property (@(posedge clk) disable iff (!rst_n)
        (ASIZE+1)'(wptr - rptr) == count);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // standard-read instance (u0) and FWFT instance (u1)
    logic       winc0 = 0, rinc0 = 0, clr0 = 0;
    logic [7:0] wdata0 = 0;
    logic       wfull0, wafull0, rempty0, raempty0, ovf0, unf0;
    logic [7:0] rdata0;
    logic [4:0] count0;

    logic       winc1 = 0, rinc1 = 0, clr1 = 0;
    logic [7:0] wdata1 = 0;
    logic       wfull1, wafull1, rempty1, raempty1, ovf1, unf1;
    logic [7:0] rdata1;
    logic [4:0] count1;

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .winc(winc0), .wdata(wdata0), .wfull(wfull0),
        .walmost_full(wafull0), .rinc(rinc0), .rdata(rdata0), .rempty(rempty0),
        .ralmost_empty(raempty0), .count(count0), .overflow(ovf0), .underflow(unf0),
        .clr_err(clr0)
    );

    sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .winc(winc1), .wdata(wdata1), .wfull(wfull1),
        .walmost_full(wafull1), .rinc(rinc1), .rdata(rdata1), .rempty(rempty1),
        .ralmost_empty(raempty1), .count(count1), .overflow(ovf1), .underflow(unf1),
        .clr_err(clr1)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         m_cnt = 0;
    int         n_total = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock of stimulus on u0; outputs sampled 1ns after the edge.
    // The scoreboard model decides acceptance from its own occupancy count.
    task automatic drive0(input logic wi, input logic ri, input logic ci, input logic [7:0] d);
        logic [7:0] e;
        bit do_w, do_r;
        winc0 = wi; rinc0 = ri; clr0 = ci; wdata0 = d;
        do_w = wi && (m_cnt != 16);
        do_r = ri && (m_cnt != 0);
        @(posedge clk);
        #1;
        winc0 = 0; rinc0 = 0; clr0 = 0;
        if (do_r) begin
            e = exp_q.pop_front();
            chk("sb_rdata", rdata0, e);
            m_cnt--;
        end
        if (do_w) begin
            exp_q.push_back(d);
            m_cnt++;
        end
    endtask

    task automatic drive1(input logic wi, input logic ri, input logic [7:0] d);
        winc1 = wi; rinc1 = ri; wdata1 = d;
        @(posedge clk);
        #1;
        winc1 = 0; rinc1 = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        m_cnt = 0;
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_rdata"}, rdata0, 8'h00);
        chk({tag, "_count"}, count0, 5'd0);
        chk({tag, "_rempty"}, rempty0, 1'b1);
        chk({tag, "_raempty"}, raempty0, 1'b1);
        chk({tag, "_wfull"}, wfull0, 1'b0);
        chk({tag, "_wafull"}, wafull0, 1'b0);
        chk({tag, "_ovf"}, ovf0, 1'b0);
        chk({tag, "_unf"}, unf0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       winc, rinc, clr;
        logic [7:0] wdata;
        logic [4:0] cnt;
        logic       full, afull, empty, aempty, ovf, unf;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic w, logic r, logic c, logic [7:0] d, logic [4:0] n,
                                logic f, logic af, logic e, logic ae, logic o, logic u,
                                logic [7:0] rd);
        vec_t v;
        v.winc = w; v.rinc = r; v.clr = c; v.wdata = d; v.cnt = n;
        v.full = f; v.afull = af; v.empty = e; v.aempty = ae; v.ovf = o; v.unf = u;
        v.rdata = rd;
        return v;
    endfunction

    initial begin
        // fill 0x01..0x10: ralmost_empty low from 3rd write, walmost_full from 12th, wfull at 16th
        vecs[0]  = mk(1,0,0,8'h01, 5'd1,  0,0,0,1,0,0,8'h00);
        vecs[1]  = mk(1,0,0,8'h02, 5'd2,  0,0,0,1,0,0,8'h00);
        vecs[2]  = mk(1,0,0,8'h03, 5'd3,  0,0,0,0,0,0,8'h00);
        vecs[3]  = mk(1,0,0,8'h04, 5'd4,  0,0,0,0,0,0,8'h00);
        vecs[4]  = mk(1,0,0,8'h05, 5'd5,  0,0,0,0,0,0,8'h00);
        vecs[5]  = mk(1,0,0,8'h06, 5'd6,  0,0,0,0,0,0,8'h00);
        vecs[6]  = mk(1,0,0,8'h07, 5'd7,  0,0,0,0,0,0,8'h00);
        vecs[7]  = mk(1,0,0,8'h08, 5'd8,  0,0,0,0,0,0,8'h00);
        vecs[8]  = mk(1,0,0,8'h09, 5'd9,  0,0,0,0,0,0,8'h00);
        vecs[9]  = mk(1,0,0,8'h0A, 5'd10, 0,0,0,0,0,0,8'h00);
        vecs[10] = mk(1,0,0,8'h0B, 5'd11, 0,0,0,0,0,0,8'h00);
        vecs[11] = mk(1,0,0,8'h0C, 5'd12, 0,1,0,0,0,0,8'h00);
        vecs[12] = mk(1,0,0,8'h0D, 5'd13, 0,1,0,0,0,0,8'h00);
        vecs[13] = mk(1,0,0,8'h0E, 5'd14, 0,1,0,0,0,0,8'h00);
        vecs[14] = mk(1,0,0,8'h0F, 5'd15, 0,1,0,0,0,0,8'h00);
        vecs[15] = mk(1,0,0,8'h10, 5'd16, 1,1,0,0,0,0,8'h00);
        // write at full: rejected, overflow
        vecs[16] = mk(1,0,0,8'hFF, 5'd16, 1,1,0,0,1,0,8'h00);
        // write+read at full: read only, head 0x01 out
        vecs[17] = mk(1,1,0,8'hEE, 5'd15, 0,1,0,0,1,0,8'h01);
        // clear error
        vecs[18] = mk(0,0,1,8'h00, 5'd15, 0,1,0,0,0,0,8'h01);
        vecs[19] = mk(0,0,0,8'h00, 5'd15, 0,1,0,0,0,0,8'h01);

        // ---- reset state ----
        #12;
        chk_reset0("rst_in");
        chk("rst_in_fwft_rdata", rdata1, 8'h00);
        chk("rst_in_fwft_rempty", rempty1, 1'b1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk_reset0("rst_out");

        // ---- fill / overflow table ----
        for (int i = 0; i < 20; i++) begin
            drive0(vecs[i].winc, vecs[i].rinc, vecs[i].clr, vecs[i].wdata);
            chk($sformatf("v%0d_count", i), count0, vecs[i].cnt);
            chk($sformatf("v%0d_wfull", i), wfull0, vecs[i].full);
            chk($sformatf("v%0d_wafull", i), wafull0, vecs[i].afull);
            chk($sformatf("v%0d_rempty", i), rempty0, vecs[i].empty);
            chk($sformatf("v%0d_raempty", i), raempty0, vecs[i].aempty);
            chk($sformatf("v%0d_ovf", i), ovf0, vecs[i].ovf);
            chk($sformatf("v%0d_unf", i), unf0, vecs[i].unf);
            chk($sformatf("v%0d_rdata", i), rdata0, vecs[i].rdata);
        end

        // ---- standard drain from 16 entries ----
        do_reset();
        for (int i = 1; i <= 16; i++) drive0(1, 0, 0, 8'(i));
        chk("drain_pre_count", count0, 5'd16);
        for (int i = 1; i <= 16; i++) begin
            drive0(0, 1, 0, 8'h00);
            chk($sformatf("drain%0d_rdata", i), rdata0, 8'(i));
        end
        chk("drain_rempty", rempty0, 1'b1);
        chk("drain_count", count0, 5'd0);
        drive0(0, 1, 0, 8'h00);
        chk("under_unf", unf0, 1'b1);
        chk("under_rdata_hold", rdata0, 8'h10);
        chk("under_count", count0, 5'd0);
        // set beats clear in the same cycle
        drive0(0, 1, 1, 8'h00);
        chk("setwins_unf", unf0, 1'b1);
        drive0(0, 0, 1, 8'h00);
        chk("clr_unf", unf0, 1'b0);

        // ---- steady state at count=8, pointers wrap ----
        for (int k = 0; k < 8; k++) drive0(1, 0, 0, 8'(8'h20 + k));
        chk("ss_pre_count", count0, 5'd8);
        for (int k = 0; k < 40; k++) begin
            drive0(1, 1, 0, 8'(8'h40 + k));
            chk($sformatf("ss%0d_count", k), count0, 5'd8);
        end
        chk("ss_ovf", ovf0, 1'b0);
        chk("ss_unf", unf0, 1'b0);
        chk("ss_sb_depth", exp_q.size(), 8);

        // ---- FWFT instance ----
        drive1(1, 0, 8'hA5);
        chk("fwft_a5_rempty", rempty1, 1'b0);
        chk("fwft_a5_rdata", rdata1, 8'hA5);
        drive1(1, 0, 8'h5A);
        chk("fwft_hold_rdata", rdata1, 8'hA5);
        chk("fwft_cnt2", count1, 5'd2);
        drive1(0, 1, 8'h00);
        chk("fwft_pop1_rdata", rdata1, 8'h5A);
        chk("fwft_pop1_rempty", rempty1, 1'b0);
        drive1(0, 1, 8'h00);
        chk("fwft_pop2_rempty", rempty1, 1'b1);
        chk("fwft_pop2_rdata", rdata1, 8'h00);
        chk("fwft_unf", unf1, 1'b0);

        // ---- reset mid-operation at count=9 with overflow ----
        for (int k = 0; k < 9; k++) drive0(1, 0, 0, 8'(8'h80 + k));
        chk("mid_full", wfull0, 1'b1);
        for (int k = 0; k < 7; k++) drive0(0, 1, 0, 8'h00);
        chk("mid_pre_count", count0, 5'd9);
        chk("mid_pre_ovf", ovf0, 1'b1);
        #3;
        rst_n = 0;
        #1;
        chk_reset0("mid_rst");
        exp_q.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1;
        drive0(1, 0, 0, 8'h3C);
        chk("post_rst_count", count0, 5'd1);
        drive0(0, 1, 0, 8'h00);
        chk("post_rst_rdata", rdata0, 8'h3C);
        chk("post_rst_rempty", rempty0, 1'b1);

        // ---- final report ----
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
